lc3b_mem_if: RTL and testbench
==============================

// Module: lc3b_mem_if
// PURPOSE
//   Memory interface stage fed by the LC-3b control unit. Holds MAR and MDR, runs read/write cycles
//   to a fixed-wait-state synchronous memory, and returns the one-cycle ready pulse (r) that the
//   control FSM polls in its memory states. Handles LC-3b byte/word sizing and byte lanes.
// PARAMETERS
//   MEM_WAIT  4   wait-state cycles per access (legal 1..15); mem_req stays high this many cycles
// PORTS
//   clk_50       in   1   system clock; all logic on posedge
//   rst_n        in   1   reset, synchronous, active-low
//   bus_in       in   16  processor bus value
//   ld_mar       in   1   load MAR from bus_in
//   ld_mdr       in   1   load MDR (from bus when mio_en=0, from memory when mio_en=1)
//   mio_en       in   1   request a memory access
//   rw           in   1   1=write MDR to mem[MAR], 0=read
//   data_size    in   1   1=word, 0=byte
//   r            out  1   access complete, one-cycle pulse
//   mdr_out      out  16  MDR as gated onto bus (byte reads sign-extended)
//   mar_out      out  16  current MAR
//   unaligned    out  1   misaligned word access flagged (see CONFIGURATION)
//   mem_req      out  1   memory cycle active
//   mem_we       out  1   write strobe, valid while mem_req
//   mem_be       out  2   byte enables {hi,lo}
//   mem_addr     out  16  {MAR[15:1],1'b0}
//   mem_wdata    out  16  MDR
//   mem_rdata    in   16  read data, valid on final wait cycle
// BEHAVIOUR
//   Reset (rst_n=0 at edge): MAR=0, MDR=0, state IDLE, cnt=0. Outputs r=0, mem_req=0, mem_we=0,
//     mem_be=0, unaligned=0. Reset mid-access aborts it: no r pulse, mem_req drops next edge.
//   FSM: IDLE -> ACCESS when mio_en=1. ACCESS counts cnt 0..MEM_WAIT-1, then -> DONE.
//     DONE lasts one cycle (r=1) -> IDLE. mio_en is ignored in DONE, so accesses are separated by
//     at least one idle cycle. mio_en held high after r therefore starts a new access.
//   Latency: mio_en sampled at edge t -> r high in cycle t+MEM_WAIT+1.
//   Start-of-access capture: rw, data_size, and the address latched from next-MAR, so ld_mar with
//     mio_en in the same IDLE cycle uses bus_in.
//   ld_mar while ACCESS/DONE: ignored (MAR frozen). ld_mdr with mio_en=0 while ACCESS: ignored.
//   Read: MDR <= mem_rdata at the ACCESS->DONE edge if ld_mdr is high in that cycle. Otherwise MDR
//     is unchanged.
//   mem_be: word = 2'b11. Byte = MAR[0] ? 2'b10 : 2'b01. mem_we = rw during ACCESS.
//   Bus load with byte size: MDR <= {bus_in[7:0],bus_in[7:0]}. Word size: MDR <= bus_in.
//   mdr_out: word = MDR. Byte = sext(MAR[0] ? MDR[15:8] : MDR[7:0]) to 16 bits.
//   MAR value 16'hFFFF: no wrap logic needed; the address is passed through as given.
// CONFIGURATION
//   LC3B_UNALIGNED_TRAP_EN defined: a word access with MAR[0]=1 issues no mem_req.
//     IDLE -> DONE directly: r=1 and unaligned=1 in the same cycle. unaligned holds until the
//     next access starts or reset.
//   LC3B_UNALIGNED_TRAP_EN undefined: unaligned is tied 0. Such accesses proceed normally at
//     the word address {MAR[15:1],0}.
// STRUCTURE
//   lc3b_pkg: FSM state encoding (IDLE/ACCESS/DONE), SIZE_BYTE/SIZE_WORD, RW_READ/RW_WRITE.
//   Sub-module lc3b_byte_lane (combinational): byte-enable generation, write replication,
//     read select with sign extension. Instantiated once.
// TESTING
//   1. MEM_WAIT=4, MAR=0x3000, word read, mem_rdata=0xBEEF, ld_mdr=1 -> mem_req high 4 cycles;
//      r pulses in cycle t+5; mdr_out=0xBEEF.
//   2. Byte read, MAR=0x3001, mem_rdata=0x80FF -> mem_be=2'b10; mdr_out=0xFF80.
//   3. Byte write, bus=0x1234, MAR=0x4000 -> mem_wdata=0x3434, mem_be=2'b01, mem_we=1 for 4 cycles.
//   4. mio_en held high across r -> exactly one idle cycle, then a second access.
//      ld_mar pulsed mid-access -> MAR unchanged.
//   5. rst_n=0 on the 2nd wait cycle -> no r, mem_req=0 next cycle, MAR=MDR=0.
//   6. LC3B_UNALIGNED_TRAP_EN, word access at MAR=0x3001 -> r=1, unaligned=1 one cycle after start,
//      mem_req never asserted. Without the macro: normal access at 0x3000.

Source files
------------

// File: rtl/lc3b_pkg.sv
// Shared types for the LC-3b memory interface: FSM state encoding, size/direction codes and
// the byte sign-extension helper.
package lc3b_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StAccess = 2'b01,
      StDone   = 2'b10
   } state_e;

   localparam logic SizeByte = 1'b0;
   localparam logic SizeWord = 1'b1;
   localparam logic RwRead   = 1'b0;
   localparam logic RwWrite  = 1'b1;

   function automatic logic [15:0] sext8(input logic [7:0] b);
      return {{8{b[7]}}, b};
   endfunction

endpackage

// File: rtl/lc3b_byte_lane.sv
// Combinational byte-lane steering: byte enables, byte-write replication of the bus value,
// and byte-read selection with sign extension of the MDR.
module lc3b_byte_lane
   import lc3b_pkg::*;
(
   input  logic        be_size_i,
   input  logic        be_addr0_i,
   input  logic        sel_size_i,
   input  logic        sel_addr0_i,
   input  logic [15:0] bus_i,
   input  logic [15:0] mdr_i,
   output logic [1:0]  be_o,
   output logic [15:0] wdata_o,
   output logic [15:0] rdata_o
);

   always_comb begin
      be_o = 2'b11;
      if (be_size_i == SizeByte) begin
         be_o = be_addr0_i ? 2'b10 : 2'b01;
      end
   end

   // A byte store drives the same byte on both lanes; the enables pick the real one.
   always_comb begin
      wdata_o = bus_i;
      if (sel_size_i == SizeByte) begin
         wdata_o = {bus_i[7:0], bus_i[7:0]};
      end
   end

   always_comb begin
      rdata_o = mdr_i;
      if (sel_size_i == SizeByte) begin
         rdata_o = sel_addr0_i ? sext8(mdr_i[15:8]) : sext8(mdr_i[7:0]);
      end
   end

endmodule

// File: rtl/lc3b_mem_if.sv
// LC-3b memory interface: MAR/MDR, fixed-wait-state access FSM and one-cycle ready pulse.
// Define LC3B_UNALIGNED_TRAP_EN to trap misaligned word accesses instead of issuing them.
module lc3b_mem_if
   import lc3b_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 4
) (
   input  logic        clk_50,
   input  logic        rst_n,
   input  logic [15:0] bus_in,
   input  logic        ld_mar,
   input  logic        ld_mdr,
   input  logic        mio_en,
   input  logic        rw,
   input  logic        data_size,
   output logic        r,
   output logic [15:0] mdr_out,
   output logic [15:0] mar_out,
   output logic        unaligned,
   output logic        mem_req,
   output logic        mem_we,
   output logic [1:0]  mem_be,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata
);

   localparam logic [3:0] CntLast = 4'(MEM_WAIT - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] mar_q, mar_d;
   logic [15:0] mdr_q, mdr_d;
   logic        rw_q, rw_d;
   logic        size_q, size_d;
   logic        r_q, r_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [1:0]  mem_be_q, mem_be_d;
   logic        trap;
   logic [1:0]  lane_be;
   logic [15:0] lane_wdata;
   logic [15:0] lane_rdata;

   // MAR only moves in IDLE, so the address an access starts with stays put until it ends.
   assign mar_d = (state_q == StIdle && ld_mar) ? bus_in : mar_q;

`ifdef LC3B_UNALIGNED_TRAP_EN
   logic unaligned_q, unaligned_d;

   assign trap = (data_size == SizeWord) && mar_d[0];

   always_comb begin
      unaligned_d = unaligned_q;
      if (state_q == StIdle && mio_en) begin
         unaligned_d = trap;
      end
   end

   always_ff @(posedge clk_50) begin
      if (!rst_n) begin
         unaligned_q <= 1'b0;
      end else begin
         unaligned_q <= unaligned_d;
      end
   end

   assign unaligned = unaligned_q;
`else
   assign trap      = 1'b0;
   assign unaligned = 1'b0;
`endif

   lc3b_byte_lane u_byte_lane (
      .be_size_i   (size_d),
      .be_addr0_i  (mar_d[0]),
      .sel_size_i  (data_size),
      .sel_addr0_i (mar_q[0]),
      .bus_i       (bus_in),
      .mdr_i       (mdr_q),
      .be_o        (lane_be),
      .wdata_o     (lane_wdata),
      .rdata_o     (lane_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mdr_d   = mdr_q;
      rw_d    = rw_q;
      size_d  = size_q;
      unique case (state_q)
         StIdle: begin
            if (mio_en) begin
               rw_d    = rw;
               size_d  = data_size;
               cnt_d   = 4'd0;
               state_d = trap ? StDone : StAccess;
            end else if (ld_mdr) begin
               mdr_d = lane_wdata;
            end
         end
         StAccess: begin
            if (cnt_q == CntLast) begin
               cnt_d   = 4'd0;
               state_d = StDone;
               if (ld_mdr) begin
                  mdr_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StDone: begin
            // mio_en is not looked at here, guaranteeing an idle cycle between accesses.
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      r_d       = (state_d == StDone);
      mem_req_d = (state_d == StAccess);
      mem_we_d  = (state_d == StAccess) && (rw_d == RwWrite);
      mem_be_d  = (state_d == StAccess) ? lane_be : 2'b00;
   end

   always_ff @(posedge clk_50) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         mar_q     <= 16'h0000;
         mdr_q     <= 16'h0000;
         rw_q      <= RwRead;
         size_q    <= SizeByte;
         r_q       <= 1'b0;
         mem_req_q <= 1'b0;
         mem_we_q  <= 1'b0;
         mem_be_q  <= 2'b00;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mar_q     <= mar_d;
         mdr_q     <= mdr_d;
         rw_q      <= rw_d;
         size_q    <= size_d;
         r_q       <= r_d;
         mem_req_q <= mem_req_d;
         mem_we_q  <= mem_we_d;
         mem_be_q  <= mem_be_d;
      end
   end

   assign r         = r_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mar_out   = mar_q;
   assign mdr_out   = lane_rdata;
   assign mem_addr  = {mar_q[15:1], 1'b0};
   assign mem_wdata = mdr_q;

endmodule

// File: tb/tb_lc3b_mem_if.sv
// Directed bench for lc3b_mem_if (MEM_WAIT=4); expected MDR values are queued at access start
// and compared when r pulses.
module tb_lc3b_mem_if;

   logic        clk_50 = 1'b0;
   logic        rst_n;
   logic [15:0] bus_in;
   logic        ld_mar, ld_mdr, mio_en, rw, data_size;
   logic        r, unaligned, mem_req, mem_we;
   logic [15:0] mdr_out, mar_out, mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  mem_be;

   int n_pass = 0;
   int n_total = 0;
   int n_fail = 0;
   logic [15:0] exp_q[$];

   lc3b_mem_if #(.MEM_WAIT(4)) dut (
      .clk_50    (clk_50),
      .rst_n     (rst_n),
      .bus_in    (bus_in),
      .ld_mar    (ld_mar),
      .ld_mdr    (ld_mdr),
      .mio_en    (mio_en),
      .rw        (rw),
      .data_size (data_size),
      .r         (r),
      .mdr_out   (mdr_out),
      .mar_out   (mar_out),
      .unaligned (unaligned),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk_50 = ~clk_50;

   task automatic tick();
      @(posedge clk_50);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Runs until r is seen (bounded), counting mem_req / mem_we cycles on the way.
   task automatic wait_r(output int lat, output int req, output int we);
      lat = 0;
      req = 0;
      we  = 0;
      while (r !== 1'b1 && lat < 40) begin
         if (mem_req === 1'b1) req++;
         if (mem_we === 1'b1) we++;
         tick();
         lat++;
      end
   endtask

   task automatic pop_check(input string tag);
      logic [15:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 16'(exp_q.size()), 16'd1);
      end else begin
         e = exp_q.pop_front();
         check(tag, mdr_out, e);
      end
   endtask

   initial begin
      int lat, req, we;
      rst_n = 1'b0; bus_in = '0; ld_mar = 0; ld_mdr = 0; mio_en = 0; rw = 0; data_size = 1;
      mem_rdata = '0;
      tick();
      tick();
      check("rst_r", {15'd0, r}, 16'd0);
      check("rst_mem_req", {15'd0, mem_req}, 16'd0);
      check("rst_mem_we", {15'd0, mem_we}, 16'd0);
      check("rst_mem_be", {14'd0, mem_be}, 16'd0);
      check("rst_unaligned", {15'd0, unaligned}, 16'd0);
      check("rst_mar", mar_out, 16'h0000);
      check("rst_mdr", mdr_out, 16'h0000);
      rst_n = 1'b1;

      // 1: word read at 0x3000
      bus_in = 16'h3000; ld_mar = 1; tick(); ld_mar = 0;
      check("t1_mar", mar_out, 16'h3000);
      rw = 0; data_size = 1; ld_mdr = 1; mem_rdata = 16'hBEEF; mio_en = 1;
      exp_q.push_back(16'hBEEF);
      tick(); mio_en = 0;
      check("t1_be", {14'd0, mem_be}, 16'h0003);
      check("t1_addr", mem_addr, 16'h3000);
      wait_r(lat, req, we);
      ld_mdr = 0;
      check("t1_r_seen", {15'd0, r}, 16'd1);
      check("t1_latency", 16'(lat + 1), 16'd5);
      check("t1_req_cycles", 16'(req), 16'd4);
      pop_check("t1_mdr");
      tick();
      check("t1_r_pulse", {15'd0, r}, 16'd0);

      // 2: byte read at 0x3001; MAR loaded in the same cycle as mio_en
      bus_in = 16'h3001; ld_mar = 1; mio_en = 1; data_size = 0; rw = 0; ld_mdr = 1;
      mem_rdata = 16'h80FF;
      exp_q.push_back(16'hFF80);
      tick(); ld_mar = 0; mio_en = 0;
      check("t2_be", {14'd0, mem_be}, 16'h0002);
      check("t2_addr", mem_addr, 16'h3000);
      wait_r(lat, req, we);
      ld_mdr = 0;
      check("t2_latency", 16'(lat + 1), 16'd5);
      pop_check("t2_mdr");
      tick();

      // 3: byte write 0x34 to 0x4000
      bus_in = 16'h4000; ld_mar = 1; tick(); ld_mar = 0;
      bus_in = 16'h1234; data_size = 0; ld_mdr = 1; tick(); ld_mdr = 0;
      check("t3_mdr_byte", mdr_out, 16'h0034);
      rw = 1; mio_en = 1;
      exp_q.push_back(16'h0034);
      tick(); mio_en = 0;
      check("t3_wdata", mem_wdata, 16'h3434);
      check("t3_be", {14'd0, mem_be}, 16'h0001);
      wait_r(lat, req, we);
      check("t3_we_cycles", 16'(we), 16'd4);
      pop_check("t3_mdr");
      tick();
      check("t3_we_off", {15'd0, mem_we}, 16'd0);

      // 4: back-to-back with mio_en held; ld_mar mid-access ignored
      bus_in = 16'h5000; ld_mar = 1; tick(); ld_mar = 0;
      rw = 0; data_size = 1; ld_mdr = 1; mem_rdata = 16'hABCD; mio_en = 1;
      exp_q.push_back(16'hABCD);
      tick();
      wait_r(lat, req, we);
      ld_mdr = 0;
      pop_check("t4a_mdr");
      exp_q.push_back(16'hABCD);
      tick();
      check("t4_idle_req", {15'd0, mem_req}, 16'd0);
      check("t4_idle_r", {15'd0, r}, 16'd0);
      tick();
      check("t4_second_req", {15'd0, mem_req}, 16'd1);
      mio_en = 0; bus_in = 16'h7777; ld_mar = 1; tick(); ld_mar = 0;
      check("t4_mar_frozen", mar_out, 16'h5000);
      wait_r(lat, req, we);
      check("t4b_r_seen", {15'd0, r}, 16'd1);
      pop_check("t4b_mdr");
      tick();

      // 5: reset during the second wait cycle
      bus_in = 16'h6000; ld_mar = 1; tick(); ld_mar = 0;
      mio_en = 1; tick(); mio_en = 0;
      tick();
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      check("t5_req", {15'd0, mem_req}, 16'd0);
      check("t5_r", {15'd0, r}, 16'd0);
      check("t5_mar", mar_out, 16'h0000);
      check("t5_mdr", mdr_out, 16'h0000);
      req = 0;
      for (int i = 0; i < 8; i++) begin
         if (r === 1'b1 || mem_req === 1'b1) req++;
         tick();
      end
      check("t5_no_activity", 16'(req), 16'd0);

      // 6: misaligned word access at 0x3001
      bus_in = 16'h3001; ld_mar = 1; tick(); ld_mar = 0;
      data_size = 1; rw = 0; mio_en = 1;
      exp_q.push_back(16'h0000);
      tick(); mio_en = 0;
`ifdef LC3B_UNALIGNED_TRAP_EN
      check("t6_trap_r", {15'd0, r}, 16'd1);
      check("t6_trap_unaligned", {15'd0, unaligned}, 16'd1);
      check("t6_trap_req", {15'd0, mem_req}, 16'd0);
      pop_check("t6_mdr");
      tick();
      check("t6_unaligned_hold", {15'd0, unaligned}, 16'd1);
`else
      check("t6_addr", mem_addr, 16'h3000);
      check("t6_be", {14'd0, mem_be}, 16'h0003);
      wait_r(lat, req, we);
      check("t6_latency", 16'(lat + 1), 16'd5);
      check("t6_unaligned", {15'd0, unaligned}, 16'd0);
      pop_check("t6_mdr");
      tick();
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
